// File: rtl/trisc_mem_arbiter_if.sv
// Bus bundle linking the TRISC memory arbiter to its CPU and DMA requesters
// and to the shared memory. The slave side is the arbiter.
interface trisc_mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_lock;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_oe;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output mem_addr, mem_wdata, mem_we, mem_oe, busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_oe, busy, owner
    );
endinterface

// File: rtl/trisc_mem_arbiter.sv
// Two-way arbiter for the single TRISC memory: CPU sequencer vs DMA/loader.
// One access at a time, WAIT strobe cycles, then a one-cycle ack; falling-edge clocked.
module trisc_mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int WAIT     = 2,
    parameter int LOCK_MAX = 4
) (
    input  logic               CLK,
    input  logic               CLR,
    trisc_mem_arbiter_if.slave bus
);
    localparam int            CW       = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam int            LW       = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT - 1);
    localparam logic [LW-1:0] LOCK_TOP = LW'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t        state, next_state;
    logic [CW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic          we_q, owner_q, last_owner, prev_lock;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, cpu_rdata_q, dma_rdata_q;
    logic          grant, grant_dma, lock_hit;
    logic          cpu_ack, dma_ack, mem_we, mem_oe, busy;

    // Winner selection; only consumed while IDLE. A locked DMA burst beats the tie rule.
    always_comb begin
        lock_hit = last_owner && prev_lock && bus.dma_req && bus.dma_lock && (lock_cnt < LOCK_TOP);
        grant    = bus.cpu_req || bus.dma_req;
        if (lock_hit)
            grant_dma = 1'b1;
        else if (bus.cpu_req && bus.dma_req)
            grant_dma = ~last_owner;
        else
            grant_dma = bus.dma_req;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge CLK or negedge CLR) begin
        if (!CLR) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant) next_state = ACCESS;
            ACCESS:  if (wait_cnt == '0) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        cpu_ack = 1'b0;
        dma_ack = 1'b0;
        mem_we  = 1'b0;
        mem_oe  = 1'b0;
        busy    = 1'b0;
        case (state)
            ACCESS: begin
                busy   = 1'b1;
                mem_we = we_q;
                mem_oe = ~we_q;
            end
            ACK: begin
                busy    = 1'b1;
                cpu_ack = ~owner_q;
                dma_ack = owner_q;
            end
            default: ;
        endcase
    end

    always_ff @(negedge CLK or negedge CLR) begin
        if (!CLR) begin
            wait_cnt    <= '0;
            lock_cnt    <= '0;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            last_owner  <= 1'b1;
            prev_lock   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    wait_cnt   <= CNT_LOAD;
                    owner_q    <= grant_dma;
                    last_owner <= grant_dma;
                    if (grant_dma) begin
                        addr_q    <= bus.dma_addr;
                        wdata_q   <= bus.dma_wdata;
                        we_q      <= bus.dma_we;
                        prev_lock <= bus.dma_lock;
                        // Unlocked DMA grants restart the burst; a plain grant with lock set keeps the count.
                        if (lock_hit)
                            lock_cnt <= lock_cnt + LW'(1);
                        else if (!bus.dma_lock)
                            lock_cnt <= '0;
                    end else begin
                        addr_q   <= bus.cpu_addr;
                        wdata_q  <= bus.cpu_wdata;
                        we_q     <= bus.cpu_we;
                        lock_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != '0)
                        wait_cnt <= wait_cnt - CW'(1);
                    else if (!we_q) begin
                        if (owner_q) dma_rdata_q <= bus.mem_rdata;
                        else         cpu_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack;
    assign bus.dma_ack   = dma_ack;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = mem_we;
    assign bus.mem_oe    = mem_oe;
    assign bus.busy      = busy;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_trisc_mem_arbiter.sv
// Bench for trisc_mem_arbiter: directed access table, abort/WAIT=1 sequences,
// then random traffic against a timestamp-based transaction model.
module tb_trisc_mem_arbiter;
    localparam int WAIT     = 2;
    localparam int LOCK_MAX = 4;

    logic CLK = 1'b1;
    logic CLR;
    always #5 CLK = ~CLK;

    trisc_mem_arbiter_if #(.AW(8), .DW(8)) bus ();
    trisc_mem_arbiter_if #(.AW(8), .DW(8)) bus1 ();

    trisc_mem_arbiter #(.AW(8), .DW(8), .WAIT(WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .CLK(CLK), .CLR(CLR), .bus(bus)
    );
    trisc_mem_arbiter #(.AW(8), .DW(8), .WAIT(1), .LOCK_MAX(LOCK_MAX)) dut1 (
        .CLK(CLK), .CLR(CLR), .bus(bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_ack = 0;

    always @(negedge CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs0();
        return {26'd0, bus.cpu_ack, bus.dma_ack, bus.mem_we, bus.mem_oe, bus.busy, bus.owner,
                bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata};
    endfunction

    task automatic idle_inputs();
        bus.cpu_req  = 0; bus.cpu_we  = 0; bus.cpu_addr  = 0; bus.cpu_wdata  = 0;
        bus.dma_req  = 0; bus.dma_we  = 0; bus.dma_addr  = 0; bus.dma_wdata  = 0;
        bus.dma_lock = 0; bus.mem_rdata = 0;
        bus1.cpu_req  = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
        bus1.dma_req  = 0; bus1.dma_we = 0; bus1.dma_addr = 0; bus1.dma_wdata = 0;
        bus1.dma_lock = 0; bus1.mem_rdata = 0;
    endtask

    // One directed access: requests presented in an IDLE cycle, result checked at the ack.
    typedef struct {
        bit         rst;
        bit         cr, dr, dl, cwe, dwe;
        logic [7:0] caddr, daddr, cdat, ddat, rdat;
        bit         e_dma;
        logic [7:0] e_crd, e_drd;
    } vec_t;

    function automatic vec_t mk(input bit rst, cr, dr, dl, cwe, dwe,
                                input logic [7:0] caddr, daddr, cdat, ddat, rdat,
                                input bit e_dma, input logic [7:0] e_crd, e_drd);
        vec_t v;
        v.rst = rst; v.cr = cr; v.dr = dr; v.dl = dl; v.cwe = cwe; v.dwe = dwe;
        v.caddr = caddr; v.daddr = daddr; v.cdat = cdat; v.ddat = ddat; v.rdat = rdat;
        v.e_dma = e_dma; v.e_crd = e_crd; v.e_drd = e_drd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input bit chk_gap);
        int         n, we_n, oe_n;
        bit         bus_ok, e_we;
        logic [7:0] e_addr, e_wd;
        e_addr = v.e_dma ? v.daddr : v.caddr;
        e_wd   = v.e_dma ? v.ddat  : v.cdat;
        e_we   = v.e_dma ? v.dwe   : v.cwe;
        if (v.rst) begin
            @(posedge CLK);
            CLR = 0;
            idle_inputs();
            #2;
            check("reset_outputs", outs0(), 64'd0);
            CLR = 1;
        end
        @(posedge CLK);
        check("idle_quiet", {bus.cpu_ack, bus.dma_ack, bus.busy, bus.mem_we, bus.mem_oe}, 64'd0);
        bus.cpu_req = v.cr; bus.cpu_we = v.cwe; bus.cpu_addr = v.caddr; bus.cpu_wdata = v.cdat;
        bus.dma_req = v.dr; bus.dma_we = v.dwe; bus.dma_addr = v.daddr; bus.dma_wdata = v.ddat;
        bus.dma_lock = v.dl; bus.mem_rdata = v.rdat;
        n = 0;
        @(posedge CLK);
        while (!bus.busy && n < 8) begin @(posedge CLK); n++; end
        we_n = 0; oe_n = 0; bus_ok = 1;
        while (bus.busy && !(bus.cpu_ack || bus.dma_ack) && n < 16) begin
            we_n += int'(bus.mem_we);
            oe_n += int'(bus.mem_oe);
            if (bus.mem_addr !== e_addr || bus.mem_wdata !== e_wd) bus_ok = 0;
            @(posedge CLK);
            n++;
        end
        check("ack_select", {bus.cpu_ack, bus.dma_ack}, v.e_dma ? 64'd1 : 64'd2);
        check("owner", bus.owner, v.e_dma);
        check("strobe_cycles", {32'(we_n), 32'(oe_n)},
              e_we ? {32'(WAIT), 32'd0} : {32'd0, 32'(WAIT)});
        check("addr_wdata_stable", bus_ok, 1);
        check("rdata", {bus.cpu_rdata, bus.dma_rdata}, {v.e_crd, v.e_drd});
        if (chk_gap) check("ack_spacing", cyc - last_ack, WAIT + 2);
        last_ack = cyc;
        bus.cpu_req = 0;
        bus.dma_req = 0;
    endtask

    // Transaction model: an access granted at falling edge mg owns cycles mg..mg+WAIT.
    int         mc, mg, m_run;
    bit         m_dma, m_we, m_last, m_plock, m_owner;
    logic [7:0] m_addr, m_wdata, m_crd, m_drd;

    function automatic logic [63:0] exp_outs();
        int e;
        bit s, a;
        e = mc - mg;
        s = (e >= 0) && (e < WAIT);
        a = (e == WAIT);
        return {26'd0, a && !m_dma, a && m_dma, s && m_we, s && !m_we, s || a, m_owner,
                m_addr, m_wdata, m_crd, m_drd};
    endfunction

    task automatic model_step();
        int n;
        bit ovr, win;
        n = mc + 1;
        if (n - mg == WAIT && !m_we) begin
            if (m_dma) m_drd = bus.mem_rdata;
            else       m_crd = bus.mem_rdata;
        end
        if (mc - mg >= WAIT + 1 && (bus.cpu_req || bus.dma_req)) begin
            ovr = m_last && m_plock && bus.dma_req && bus.dma_lock && (m_run < LOCK_MAX);
            win = ovr ? 1'b1 : (bus.cpu_req && bus.dma_req) ? !m_last : bus.dma_req;
            if (!win)                m_run = 0;
            else if (ovr)            m_run = m_run + 1;
            else if (!bus.dma_lock)  m_run = 0;
            if (win) m_plock = bus.dma_lock;
            m_dma = win; m_last = win; m_owner = win;
            m_we    = win ? bus.dma_we    : bus.cpu_we;
            m_addr  = win ? bus.dma_addr  : bus.cpu_addr;
            m_wdata = win ? bus.dma_wdata : bus.cpu_wdata;
            mg = n;
        end
        mc = n;
    endtask

    task automatic rand_drive();
        int e;
        bit acc;
        e   = mc - mg;
        acc = (e >= 0) && (e < WAIT);
        if (e == WAIT && !m_dma) bus.cpu_req = 0;
        else if (!bus.cpu_req && $urandom_range(2) == 0) begin
            bus.cpu_req = 1; bus.cpu_we = 1'($urandom);
            bus.cpu_addr = 8'($urandom); bus.cpu_wdata = 8'($urandom);
        end else if (acc && !m_dma) begin
            bus.cpu_addr = 8'($urandom); bus.cpu_wdata = 8'($urandom);
        end
        if (e == WAIT && m_dma) bus.dma_req = 0;
        else if (!bus.dma_req && $urandom_range(2) == 0) begin
            bus.dma_req = 1; bus.dma_we = 1'($urandom);
            bus.dma_addr = 8'($urandom); bus.dma_wdata = 8'($urandom);
            bus.dma_lock = ($urandom_range(2) != 0);
        end else if (acc && m_dma) begin
            bus.dma_addr = 8'($urandom); bus.dma_wdata = 8'($urandom);
        end
        bus.mem_rdata = 8'($urandom);
    endtask

    initial begin
        vec_t vt[$];
        int   n, seen, oe_n, we_n, acks, t_a1, t_a2;
        logic [7:0]  rd_seen;
        logic [15:0] wr_seen;

        idle_inputs();
        CLR = 0;

        //           rst cr dr dl cwe dwe caddr  daddr  cdat   ddat   rdat   dma crd    drd
        vt.push_back(mk(1, 1, 0, 0, 0, 0, 8'h12, 8'h00, 8'h00, 8'h00, 8'hA5, 0, 8'hA5, 8'h00));
        vt.push_back(mk(0, 0, 1, 0, 0, 1, 8'h00, 8'h30, 8'h00, 8'h5C, 8'hEE, 1, 8'hA5, 8'h00));
        vt.push_back(mk(1, 1, 1, 0, 0, 0, 8'h40, 8'h41, 8'h00, 8'h00, 8'h11, 0, 8'h11, 8'h00));
        vt.push_back(mk(0, 1, 1, 0, 0, 0, 8'h40, 8'h41, 8'h00, 8'h00, 8'h22, 1, 8'h11, 8'h22));
        vt.push_back(mk(0, 1, 1, 0, 0, 0, 8'h40, 8'h41, 8'h00, 8'h00, 8'h33, 0, 8'h33, 8'h22));
        vt.push_back(mk(0, 1, 1, 0, 1, 1, 8'h50, 8'h51, 8'h77, 8'h88, 8'h44, 1, 8'h33, 8'h22));
        vt.push_back(mk(0, 1, 0, 0, 1, 0, 8'h60, 8'h00, 8'h99, 8'h00, 8'h55, 0, 8'h33, 8'h22));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 8'h71, 8'h70, 8'h00, 8'h00, 8'h01, 1, 8'h33, 8'h01));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(0, 1, 1, 1, 0, 0, 8'h71, 8'h70, 8'h00, 8'h00, 8'(2 + k), 1, 8'h33, 8'(2 + k)));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 8'h71, 8'h70, 8'h00, 8'h00, 8'h06, 0, 8'h06, 8'h05));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 8'h71, 8'h70, 8'h00, 8'h00, 8'h07, 1, 8'h06, 8'h07));
        for (int k = 0; k < 6; k++)
            vt.push_back(mk(0, 0, 1, 1, 0, 0, 8'h00, 8'h70, 8'h00, 8'h00, 8'(8'h20 + k), 1, 8'h06, 8'(8'h20 + k)));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 8'h71, 8'h70, 8'h00, 8'h00, 8'h30, 0, 8'h30, 8'h25));
        vt.push_back(mk(0, 1, 1, 0, 0, 0, 8'h71, 8'h70, 8'h00, 8'h00, 8'h31, 1, 8'h30, 8'h31));
        vt.push_back(mk(0, 1, 1, 0, 0, 0, 8'h71, 8'h70, 8'h00, 8'h00, 8'h32, 0, 8'h32, 8'h31));

        foreach (vt[i]) run_vec(vt[i], !vt[i].rst);

        // Reset in the first write strobe cycle: strobes fall at once, no ack follows.
        @(posedge CLK);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h21; bus.cpu_wdata = 8'h3C;
        n = 0;
        @(posedge CLK);
        while (!bus.busy && n < 8) begin @(posedge CLK); n++; end
        check("abort_we_before", bus.mem_we, 1);
        #1 CLR = 0;
        #1 check("abort_outputs", outs0(), 64'd0);
        bus.cpu_req = 0;
        CLR = 1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK);
            seen += int'(bus.cpu_ack || bus.dma_ack || bus.busy);
        end
        check("abort_no_ack", seen, 0);
        run_vec(mk(0, 1, 1, 0, 0, 0, 8'h22, 8'h23, 8'h00, 8'h00, 8'h66, 0, 8'h66, 8'h00), 0);

        // Random traffic against the model.
        @(posedge CLK);
        CLR = 0;
        idle_inputs();
        #2 CLR = 1;
        mc = 0; mg = -100; m_run = 0;
        m_dma = 0; m_we = 0; m_last = 1; m_plock = 0; m_owner = 0;
        m_addr = 0; m_wdata = 0; m_crd = 0; m_drd = 0;
        for (int i = 0; i < 1500; i++) begin
            rand_drive();
            model_step();
            @(posedge CLK);
            check("random_outputs", outs0(), exp_outs());
        end
        idle_inputs();

        // WAIT=1 instance: read then write, request held straight through the first ACK.
        @(posedge CLK);
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 8'h0A; bus1.mem_rdata = 8'h6B;
        oe_n = 0; we_n = 0; acks = 0; seen = 0; t_a1 = 0; t_a2 = 0;
        rd_seen = 0; wr_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            oe_n += int'(bus1.mem_oe);
            we_n += int'(bus1.mem_we);
            seen += int'(bus1.dma_ack);
            if (bus1.mem_we) wr_seen = {bus1.mem_addr, bus1.mem_wdata};
            if (bus1.cpu_ack) begin
                acks++;
                if (acks == 1) begin
                    t_a1 = cyc;
                    rd_seen = bus1.cpu_rdata;
                    bus1.cpu_we = 1; bus1.cpu_addr = 8'h0B; bus1.cpu_wdata = 8'hD4;
                end else begin
                    t_a2 = cyc;
                    bus1.cpu_req = 0;
                end
            end
        end
        check("w1_ack_count", acks, 2);
        check("w1_oe_cycles", oe_n, 1);
        check("w1_we_cycles", we_n, 1);
        check("w1_ack_spacing", t_a2 - t_a1, 3);
        check("w1_read_data", rd_seen, 8'h6B);
        check("w1_write_bus", wr_seen, 16'h0BD4);
        check("w1_rdata_kept", bus1.cpu_rdata, 8'h6B);
        check("w1_no_dma_ack", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trisc_mem_arbiter.md
Name: trisc_mem_arbiter

Overview:
- Shares the single TRISC memory between two requesters: the CPU control sequencer (instruction fetch, LDA, STA) and a DMA/program-loader port.
- Grants one requester at a time and drives the memory address, data and strobes for a fixed number of wait cycles.
- Returns read data and a one-cycle acknowledge to the requester.
- Sits between the control unit / loader and the memory.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- WAIT, 2, memory access length in cycles; must be at least 1.
- LOCK_MAX, 4, maximum consecutive locked DMA accesses before the CPU is forced in.

Ports:
- CLK  input  1  clock; all registers update on the falling edge.
- CLR  input  1  reset, asynchronous, active-low.
- cpu_req  input  1  CPU access request; held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  DW  registered read data.
- dma_req  input  1  DMA access request; held until dma_ack.
- dma_we  input  1  1 = write, 0 = read.
- dma_addr  input  AW  DMA address.
- dma_wdata  input  DW  DMA write data.
- dma_lock  input  1  request back-to-back ownership.
- dma_ack  output  1  one-cycle completion pulse.
- dma_rdata  output  DW  registered read data.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_we  output  1  write strobe.
- mem_oe  output  1  read strobe.
- mem_rdata  input  DW  memory read data.
- busy  output  1  high in ACCESS and ACK.
- owner  output  1  current/last grantee: 0 = CPU, 1 = DMA.

Behaviour:
- Reset (CLR=0, asynchronous):
  - State IDLE.
  - All outputs 0: acks, strobes, mem_addr, mem_wdata, rdata registers, busy.
  - last_owner=1 (DMA), so the CPU wins the first tie.
  - lock_cnt=0, wait counter 0.
- Reset asserted mid-access aborts immediately: mem_we and mem_oe drop without waiting for an edge, and no ack is issued.

States: IDLE, ACCESS, ACK.

IDLE:
- Requests are sampled at the falling edge that leaves IDLE.
- Only one request present: grant it.
- Both requests present: grant the requester that is not last_owner.
- Lock override: if last_owner=DMA, the previous DMA access had dma_lock=1, dma_req and dma_lock are both high, and lock_cnt<LOCK_MAX, grant DMA regardless of cpu_req.
- On grant:
  - Latch addr, wdata and we from the winner into mem_addr, mem_wdata and an internal we.
  - Set owner and last_owner to the winner.
  - Load wait counter with WAIT-1 and go to ACCESS.
- No request: stay in IDLE; strobes 0; mem_addr and mem_wdata hold their last values.

ACCESS:
- Lasts exactly WAIT cycles.
- Writes drive mem_we=1, reads drive mem_oe=1, for all WAIT cycles.
- Address and write data are stable throughout; requester inputs are ignored.
- Counter decrements each edge. At the edge where counter==0:
  - For a read, capture mem_rdata into the owner's rdata register; the other rdata register holds.
  - Go to ACK.

ACK:
- The owner's ack is 1 for exactly this one cycle; strobes are 0.
- Requests are not sampled. The requester must drop req by the falling edge that ends ACK, otherwise it is treated as a new request in IDLE.
- Next state is always IDLE.

Timing:
- Grant at edge k ⇒ ack high from edge k+WAIT to k+WAIT+1.
- Back-to-back throughput is one access per WAIT+2 cycles.

Lock counter:
- DMA grant under lock override increments lock_cnt, saturating at LOCK_MAX.
- Any CPU grant, or any DMA grant with dma_lock=0, clears it to 0.
- Once lock_cnt==LOCK_MAX, the next tie goes to the CPU, which clears lock_cnt.
- If the CPU is not requesting, DMA continues without limit.

Other rules:
- rdata registers hold their value until the next read by the same requester.
- A write never changes either rdata register.

Test Plan:
1. WAIT=2; CPU read, cpu_addr=0x12, mem_rdata=0xA5 → mem_oe high for 2 cycles with mem_addr=0x12; cpu_ack pulses 1 cycle at grant+2; cpu_rdata=0xA5; dma_ack stays 0.
2. DMA write, dma_addr=0x30, dma_wdata=0x5C → mem_we high exactly 2 cycles, mem_wdata=0x5C; dma_ack pulses once; cpu_rdata and dma_rdata unchanged; owner=1.
3. cpu_req and dma_req held continuously, no lock, after reset → grants alternate CPU, DMA, CPU, DMA; each ack spaced 4 cycles apart (WAIT+2).
4. dma_lock=1 with both requests held, LOCK_MAX=4 → 5 consecutive DMA accesses (initial grant plus 4 locked), then a CPU grant, then DMA resumes; with cpu_req=0, DMA continues past 5 accesses.
5. CLR pulsed low during the first ACCESS cycle of a write → mem_we drops asynchronously, no ack issued, state IDLE, all outputs 0; the next tie is granted to the CPU.
6. WAIT=1 build; CPU read followed immediately by a CPU write → mem_oe and mem_we each high for 1 cycle; acks 3 cycles apart; requester holding req through ACK gets a second access.
